// File: rtl/msa_schedule_gen_pkg.sv
// Shared types, round counts and SHA-2 sigma helpers for the message-schedule generator.
package msa_schedule_gen_pkg;

    localparam int SHA256_ROUNDS = 64;
    localparam int SHA512_ROUNDS = 80;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } MsaSchedState;

    // x must be zero above bit w-1; the result is masked back to w bits.
    function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n,
                                         input int unsigned w);
        logic [63:0] m;
        m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return ((x >> n) | (x << (w - n))) & m;
    endfunction

    function automatic logic [63:0] shr(input logic [63:0] x, input int unsigned n);
        return x >> n;
    endfunction

    function automatic logic [31:0] sigma0_256(input logic [31:0] x);
        logic [63:0] y;
        logic [63:0] r;
        y = {32'd0, x};
        r = rotr(y, 7, 32) ^ rotr(y, 18, 32) ^ shr(y, 3);
        return r[31:0];
    endfunction

    function automatic logic [31:0] sigma1_256(input logic [31:0] x);
        logic [63:0] y;
        logic [63:0] r;
        y = {32'd0, x};
        r = rotr(y, 17, 32) ^ rotr(y, 19, 32) ^ shr(y, 10);
        return r[31:0];
    endfunction

    function automatic logic [63:0] sigma0_512(input logic [63:0] x);
        return rotr(x, 1, 64) ^ rotr(x, 8, 64) ^ shr(x, 7);
    endfunction

    function automatic logic [63:0] sigma1_512(input logic [63:0] x);
        return rotr(x, 19, 64) ^ rotr(x, 61, 64) ^ shr(x, 6);
    endfunction

endpackage

// File: rtl/msa_schedule_gen_if.sv
// Chunk-in / schedule-out handshake bundle; master = schedule generator, slave = its environment.
interface msa_schedule_gen_if #(
    parameter int WORD_W = 32,
    parameter int LANES  = 1
);
    logic                      chunk_vld;
    logic                      chunk_rdy;
    logic [16*WORD_W-1:0]      chunk_data;
    logic                      w_vld;
    logic                      w_rdy;
    logic [LANES*WORD_W-1:0]   w_data;
    logic [6:0]                w_idx;
    logic                      w_last;

    modport master (
        input  chunk_vld, chunk_data, w_rdy,
        output chunk_rdy, w_vld, w_data, w_idx, w_last
    );

    modport slave (
        output chunk_vld, chunk_data, w_rdy,
        input  chunk_rdy, w_vld, w_data, w_idx, w_last
    );
endinterface

// File: rtl/msa_sched_lane.sv
// One schedule word: W[k] = s1(W[k-2]) + W[k-7] + s0(W[k-15]) + W[k-16], purely combinational.
module msa_sched_lane
    import msa_schedule_gen_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic [WORD_W-1:0] w_m2,
    input  logic [WORD_W-1:0] w_m7,
    input  logic [WORD_W-1:0] w_m15,
    input  logic [WORD_W-1:0] w_m16,
    output logic [WORD_W-1:0] w_k
);
    logic [WORD_W-1:0] s0;
    logic [WORD_W-1:0] s1;

    generate
        if (WORD_W == 64) begin : g_512
            assign s0 = sigma0_512(w_m15);
            assign s1 = sigma1_512(w_m2);
        end else begin : g_256
            assign s0 = sigma0_256(w_m15);
            assign s1 = sigma1_256(w_m2);
        end
    endgenerate

    assign w_k = s1 + w_m7 + s0 + w_m16;
endmodule

// File: rtl/msa_schedule_gen.sv
// SHA-2 message-schedule generator: streams W[0..ROUNDS-1], LANES words per beat, from a rolling 16-word window.
// Optional completed-chunk counter port enabled by defining MSA_SCHED_CHUNK_CNT_EN.
//
// state | meaning
// IDLE  | waiting for a chunk, chunk_rdy high
// RUN   | streaming schedule beats, window shifts on each accepted beat
module msa_schedule_gen
    import msa_schedule_gen_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int ROUNDS = SHA256_ROUNDS,
    parameter int LANES  = 1
) (
    input  logic clk,
    input  logic rst,
`ifdef MSA_SCHED_CHUNK_CNT_EN
    output logic [31:0] chunk_cnt,
`endif
    msa_schedule_gen_if.master bus
);
    generate
        if (!((WORD_W == 32 && ROUNDS == SHA256_ROUNDS) ||
              (WORD_W == 64 && ROUNDS == SHA512_ROUNDS))) begin : g_bad_word
            $error("msa_schedule_gen: unsupported WORD_W/ROUNDS combination");
        end
        if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
            $error("msa_schedule_gen: LANES must be 1, 2 or 4");
        end
    endgenerate

    localparam logic [6:0] LAST_IDX = 7'(ROUNDS - LANES);
    localparam logic [6:0] IDX_STEP = 7'(LANES);

    MsaSchedState      state_q, state_d;
    logic [WORD_W-1:0] win_q [16];
    logic [WORD_W-1:0] win_d [16];
    logic [6:0]        idx_q, idx_d;
    logic [WORD_W-1:0] new_w [LANES];
    logic              accept;
    logic              fire;
    logic              last_beat;

    assign accept    = bus.chunk_vld & bus.chunk_rdy;
    assign fire      = bus.w_vld & bus.w_rdy;
    assign last_beat = (idx_q == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (fire && last_beat) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.chunk_rdy = (state_q == IDLE) && !rst;
        bus.w_vld     = (state_q == RUN);
        bus.w_last    = (state_q == RUN) && last_beat;
        bus.w_idx     = idx_q;
        bus.w_data    = '0;
        for (int j = 0; j < LANES; j++) begin
            bus.w_data[j*WORD_W +: WORD_W] = win_q[j];
        end
    end

    // Lanes 0/1 take W[k-2] from the window; higher lanes chain off the lane two below.
    generate
        for (genvar j = 0; j < LANES; j++) begin : g_lane
            logic [WORD_W-1:0] w_m2;
            if (j < 2) begin : g_win
                assign w_m2 = win_q[j+14];
            end else begin : g_chain
                assign w_m2 = new_w[j-2];
            end
            msa_sched_lane #(.WORD_W(WORD_W)) u_lane (
                .w_m2  (w_m2),
                .w_m7  (win_q[j+9]),
                .w_m15 (win_q[j+1]),
                .w_m16 (win_q[j]),
                .w_k   (new_w[j])
            );
        end
    endgenerate

    always_comb begin
        win_d = win_q;
        idx_d = idx_q;
        if (accept) begin
            for (int i = 0; i < 16; i++) begin
                win_d[i] = bus.chunk_data[i*WORD_W +: WORD_W];
            end
            idx_d = '0;
        end else if (fire) begin
            for (int i = 0; i < 16 - LANES; i++) begin
                win_d[i] = win_q[i+LANES];
            end
            for (int j = 0; j < LANES; j++) begin
                win_d[16-LANES+j] = new_w[j];
            end
            idx_d = idx_q + IDX_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= '0;
            end
            idx_q <= '0;
        end else begin
            win_q <= win_d;
            idx_q <= idx_d;
        end
    end

`ifdef MSA_SCHED_CHUNK_CNT_EN
    logic [31:0] chunk_cnt_q, chunk_cnt_d;

    always_comb begin
        chunk_cnt_d = chunk_cnt_q;
        if (fire && last_beat) chunk_cnt_d = chunk_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chunk_cnt_q <= '0;
        end else begin
            chunk_cnt_q <= chunk_cnt_d;
        end
    end

    assign chunk_cnt = chunk_cnt_q;
`endif
endmodule

// File: tb/tb_msa_schedule_gen.sv
// Directed bench for msa_schedule_gen: SHA-256 x1 / x4 lanes and SHA-512 x2 lanes against a full-array schedule model.
module tb_msa_schedule_gen;
    typedef logic [63:0] wvec_t [80];

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    msa_schedule_gen_if #(.WORD_W(32), .LANES(1)) ifa ();
    msa_schedule_gen_if #(.WORD_W(32), .LANES(4)) ifb ();
    msa_schedule_gen_if #(.WORD_W(64), .LANES(2)) ifc ();

`ifdef MSA_SCHED_CHUNK_CNT_EN
    logic [31:0] cnt_a, cnt_b, cnt_c;
`endif

    msa_schedule_gen #(.WORD_W(32), .ROUNDS(64), .LANES(1)) u_dut_a (
        .clk(clk), .rst(rst),
`ifdef MSA_SCHED_CHUNK_CNT_EN
        .chunk_cnt(cnt_a),
`endif
        .bus(ifa));
    msa_schedule_gen #(.WORD_W(32), .ROUNDS(64), .LANES(4)) u_dut_b (
        .clk(clk), .rst(rst),
`ifdef MSA_SCHED_CHUNK_CNT_EN
        .chunk_cnt(cnt_b),
`endif
        .bus(ifb));
    msa_schedule_gen #(.WORD_W(64), .ROUNDS(80), .LANES(2)) u_dut_c (
        .clk(clk), .rst(rst),
`ifdef MSA_SCHED_CHUNK_CNT_EN
        .chunk_cnt(cnt_c),
`endif
        .bus(ifc));

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] ror(input logic [63:0] x, input int n, input bit is512);
        logic [31:0] x32;
        if (is512) return (x >> n) | (x << (64 - n));
        x32 = x[31:0];
        return {32'd0, (x32 >> n) | (x32 << (32 - n))};
    endfunction

    function automatic logic [63:0] ssig0(input logic [63:0] x, input bit is512);
        if (is512) return ror(x, 1, 1'b1) ^ ror(x, 8, 1'b1) ^ (x >> 7);
        return ror(x, 7, 1'b0) ^ ror(x, 18, 1'b0) ^ (x >> 3);
    endfunction

    function automatic logic [63:0] ssig1(input logic [63:0] x, input bit is512);
        if (is512) return ror(x, 19, 1'b1) ^ ror(x, 61, 1'b1) ^ (x >> 6);
        return ror(x, 17, 1'b0) ^ ror(x, 19, 1'b0) ^ (x >> 10);
    endfunction

    task automatic build_model(input bit is512, input logic [1023:0] c, output wvec_t w);
        logic [63:0] mask;
        logic [63:0] s;
        mask = is512 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        for (int i = 0; i < 80; i++) begin
            if (i < 16) begin
                w[i] = is512 ? c[i*64 +: 64] : {32'd0, c[i*32 +: 32]};
            end else begin
                s = ssig1(w[i-2], is512) + w[i-7] + ssig0(w[i-15], is512) + w[i-16];
                w[i] = s & mask;
            end
        end
    endtask

    task automatic mon_beat(input string tag, input bit is512, input int lanes, input int rounds,
                            input logic [127:0] data, input logic [6:0] idx, input logic last,
                            input int exp_idx, input wvec_t m);
        logic [63:0] got;
        chk({tag, "_idx"}, idx, exp_idx);
        chk({tag, "_last"}, last, (exp_idx == rounds - lanes));
        for (int j = 0; j < lanes; j++) begin
            if (is512) got = data[j*64 +: 64];
            else       got = {32'd0, data[j*32 +: 32]};
            chk({tag, "_word"}, got, m[exp_idx+j]);
        end
    endtask

    wvec_t       m_a, m_b, m_c;
    int          nidx_a, nidx_b, nidx_c;
    int          done_a = 0, done_b = 0, done_c = 0;
    int          acc_cyc_a = 0, last_cyc_a = 0;
    int          stalls_b = 0;
    bit          stall_a, stall_b, stall_c;
    logic [31:0] hold_a;
    logic [127:0] hold_b, hold_c;
    logic [6:0]  hidx_a, hidx_b, hidx_c;
    logic [31:0] cap_a [64];
    logic [63:0] cap_c [80];

    always @(negedge clk) begin
        if (rst) begin
            nidx_a = 0; stall_a = 1'b0;
        end else begin
            if (ifa.chunk_vld && ifa.chunk_rdy) begin
                build_model(1'b0, {512'd0, ifa.chunk_data}, m_a);
                nidx_a = 0; acc_cyc_a = cyc + 1;
            end
            if (stall_a && ifa.w_vld) begin
                chk("a_hold_data", ifa.w_data, hold_a);
                chk("a_hold_idx", ifa.w_idx, hidx_a);
            end
            if (ifa.w_vld && ifa.w_rdy) begin
                mon_beat("a", 1'b0, 1, 64, {96'd0, ifa.w_data}, ifa.w_idx, ifa.w_last, nidx_a, m_a);
                if (nidx_a < 64) cap_a[nidx_a] = ifa.w_data;
                nidx_a += 1;
                if (ifa.w_last) begin
                    chk("a_words", nidx_a, 64);
                    done_a++; last_cyc_a = cyc + 1;
                end
            end
            stall_a = ifa.w_vld && !ifa.w_rdy; hold_a = ifa.w_data; hidx_a = ifa.w_idx;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            nidx_b = 0; stall_b = 1'b0;
        end else begin
            if (ifb.chunk_vld && ifb.chunk_rdy) begin
                build_model(1'b0, {512'd0, ifb.chunk_data}, m_b);
                nidx_b = 0;
            end
            if (stall_b && ifb.w_vld) begin
                chk("b_hold_data", ifb.w_data, hold_b);
                chk("b_hold_idx", ifb.w_idx, hidx_b);
            end
            if (ifb.w_vld && !ifb.w_rdy) stalls_b++;
            if (ifb.w_vld && ifb.w_rdy) begin
                mon_beat("b", 1'b0, 4, 64, ifb.w_data, ifb.w_idx, ifb.w_last, nidx_b, m_b);
                nidx_b += 4;
                if (ifb.w_last) begin
                    chk("b_words", nidx_b, 64);
                    done_b++;
                end
            end
            stall_b = ifb.w_vld && !ifb.w_rdy; hold_b = ifb.w_data; hidx_b = ifb.w_idx;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            nidx_c = 0; stall_c = 1'b0;
        end else begin
            if (ifc.chunk_vld && ifc.chunk_rdy) begin
                build_model(1'b1, ifc.chunk_data, m_c);
                nidx_c = 0;
            end
            if (stall_c && ifc.w_vld) begin
                chk("c_hold_data", ifc.w_data, hold_c);
                chk("c_hold_idx", ifc.w_idx, hidx_c);
            end
            if (ifc.w_vld && ifc.w_rdy) begin
                mon_beat("c", 1'b1, 2, 80, ifc.w_data, ifc.w_idx, ifc.w_last, nidx_c, m_c);
                if (nidx_c < 79) begin
                    cap_c[nidx_c]   = ifc.w_data[63:0];
                    cap_c[nidx_c+1] = ifc.w_data[127:64];
                end
                nidx_c += 2;
                if (ifc.w_last) begin
                    chk("c_words", nidx_c, 80);
                    done_c++;
                end
            end
            stall_c = ifc.w_vld && !ifc.w_rdy; hold_c = ifc.w_data; hidx_c = ifc.w_idx;
        end
    end

    function automatic int done_of(input int which);
        if (which == 0) return done_a;
        if (which == 1) return done_b;
        return done_c;
    endfunction

    task automatic send(input int which, input logic [1023:0] d);
        case (which)
            0: begin ifa.chunk_data = d[511:0]; ifa.chunk_vld = 1'b1; chk("a_rdy_idle", ifa.chunk_rdy, 1); end
            1: begin ifb.chunk_data = d[511:0]; ifb.chunk_vld = 1'b1; chk("b_rdy_idle", ifb.chunk_rdy, 1); end
            default: begin ifc.chunk_data = d; ifc.chunk_vld = 1'b1; chk("c_rdy_idle", ifc.chunk_rdy, 1); end
        endcase
        @(posedge clk); #1;
        ifa.chunk_vld = 1'b0; ifb.chunk_vld = 1'b0; ifc.chunk_vld = 1'b0;
    endtask

    task automatic wait_done(input int which, input int target, input string tag);
        int n = 0;
        while (done_of(which) < target && n < 2000) begin
            @(posedge clk); #1; n++;
        end
        chk(tag, done_of(which), target);
    endtask

    logic [511:0]  abc256, pat256;
    logic [1023:0] abc512;
    int            rdy_in_run;
    int            l1;

    initial begin
        abc256 = '0; abc256[31:0] = 32'h6162_6380; abc256[15*32 +: 32] = 32'h0000_0018;
        abc512 = '0; abc512[63:0] = 64'h6162_6380_0000_0000; abc512[15*64 +: 64] = 64'h18;
        for (int i = 0; i < 16; i++) pat256[i*32 +: 32] = 32'h9E37_79B9 * (i + 1);
        ifa.chunk_vld = 1'b0; ifa.chunk_data = '0; ifa.w_rdy = 1'b1;
        ifb.chunk_vld = 1'b0; ifb.chunk_data = '0; ifb.w_rdy = 1'b0;
        ifc.chunk_vld = 1'b0; ifc.chunk_data = '0; ifc.w_rdy = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_w_vld", ifa.w_vld, 0);
        chk("rst_w_last", ifa.w_last, 0);
        chk("rst_w_data", ifa.w_data, 0);
        chk("rst_w_idx", ifa.w_idx, 0);
        chk("rst_chunk_rdy", ifa.chunk_rdy, 0);
        chk("rst_w_data_c", ifc.w_data, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rdy_after_rst", ifa.chunk_rdy, 1);
        @(posedge clk); #1;

        // Reset in mid-stream at w_idx 20, then a clean restart
        send(0, {512'd0, abc256});
        for (int k = 0; k < 100; k++) begin
            if (ifa.w_vld && ifa.w_idx == 7'd20) break;
            @(posedge clk); #1;
        end
        chk("abort_at20", ifa.w_idx, 20);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_vld", ifa.w_vld, 0);
        chk("abort_rdy_in_rst", ifa.chunk_rdy, 0);
        chk("abort_idx", ifa.w_idx, 0);
        chk("abort_no_done", done_a, 0);
        rst = 1'b0;
        #1;
        chk("abort_rdy", ifa.chunk_rdy, 1);
        send(0, {512'd0, abc256});
        wait_done(0, 1, "a_done_restart");
`ifdef MSA_SCHED_CHUNK_CNT_EN
        chk("cnt_after_abort", cnt_a, 1);
`endif

        // SHA-256 "abc", one lane, anchor words
        for (int i = 0; i < 64; i++) cap_a[i] = '0;
        @(posedge clk); #1;
        send(0, {512'd0, abc256});
        wait_done(0, 2, "a_done_abc");
        chk("a_w0", cap_a[0], 32'h6162_6380);
        chk("a_w15", cap_a[15], 32'h0000_0018);
        chk("a_w16", cap_a[16], 32'h6162_6380);
        chk("a_w17", cap_a[17], 32'h000F_0000);
        chk("a_w18", cap_a[18], 32'h7DA8_6405);
        chk("a_w63", cap_a[63], 32'h12B1_EDEB);
`ifdef MSA_SCHED_CHUNK_CNT_EN
        chk("cnt_two", cnt_a, 2);
`endif

        // Back-to-back chunks with chunk_vld held high throughout
        @(posedge clk); #1;
        ifa.chunk_data = pat256; ifa.chunk_vld = 1'b1;
        @(posedge clk); #1;
        ifa.chunk_data = abc256;
        rdy_in_run = 0;
        for (int k = 0; k < 200 && done_a < 3; k++) begin
            @(posedge clk); #1;
            if (ifa.w_vld && ifa.chunk_rdy) rdy_in_run++;
        end
        l1 = last_cyc_a;
        @(posedge clk); #1;
        ifa.chunk_vld = 1'b0;
        chk("b2b_gap", acc_cyc_a - l1, 1);
        wait_done(0, 4, "a_done_b2b");
        chk("b2b_rdy_in_run", rdy_in_run, 0);

        // Four lanes under random backpressure
        send(1, {512'd0, abc256});
        for (int k = 0; k < 600 && done_b < 1; k++) begin
            ifb.w_rdy = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        ifb.w_rdy = 1'b1;
        chk("b_done", done_b, 1);
        chk("b_stalls_seen", stalls_b > 0, 1);

        // SHA-512, two lanes
        send(2, abc512);
        wait_done(2, 1, "c_done");
        chk("c_w0", cap_c[0], 64'h6162_6380_0000_0000);
        chk("c_w16", cap_c[16], 64'h6162_6380_0000_0000);
        chk("c_w17", cap_c[17], 64'h0003_0000_0000_00C0);

`ifdef MSA_SCHED_CHUNK_CNT_EN
        chk("cnt_four", cnt_a, 4);
        force u_dut_a.chunk_cnt_q = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        release u_dut_a.chunk_cnt_q;
        chk("cnt_forced", cnt_a, 32'hFFFF_FFFF);
        send(0, {512'd0, abc256});
        wait_done(0, 5, "a_done_wrap");
        chk("cnt_wrap", cnt_a, 0);
`endif

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
